// File: rtl/spram_bank_ctrl.sv
// spram_bank_ctrl: byte-wide controller over NUM_BANKS 16K x 16 single-port RAM banks.
// Byte lanes are steered onto the 16-bit words, bank select is decoded from the top
// address bits, and each access is a req/ack transaction of three clock edges.
// Optional feature macro: SPRAM_POWERSAVE_EN. When it is defined, the banks are put
// into SLEEP after IDLE_SLEEP_CYCLES idle cycles and held awake WAKE_CYCLES cycles
// before the first access. When it is undefined, SLEEP pins and sleeping_o are tied low.
// The per-bank memory is a behavioural stand-in for the SB_SPRAM256KA pin interface
// (CHIPSELECT, WREN, MASKWREN nibble enables, SLEEP, STANDBY, POWEROFF, registered DATAOUT).

module spram_bank_ctrl #(
    parameter int NUM_BANKS         = 2,
    parameter int IDLE_SLEEP_CYCLES = 64,
    parameter int WAKE_CYCLES       = 4,
    localparam int BANK_W           = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int ADDR_W           = 15 + BANK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o,
    output logic              ack_o,
    output logic              busy_o,
    output logic              sleeping_o
);

    // Elaboration-time parameter sanity.
    if (NUM_BANKS < 1 || NUM_BANKS > 4 || WAKE_CYCLES < 1 || IDLE_SLEEP_CYCLES < 0) begin : g_bad_param
        $error("spram_bank_ctrl: NUM_BANKS must be 1..4, WAKE_CYCLES >= 1, IDLE_SLEEP_CYCLES >= 0");
    end

`ifdef SPRAM_POWERSAVE_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_SLEEP,
        ST_WAKE
    } state_t;

    localparam int IDLE_W = (IDLE_SLEEP_CYCLES > 1) ? $clog2(IDLE_SLEEP_CYCLES) : 1;
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((IDLE_SLEEP_CYCLES > 0) ? IDLE_SLEEP_CYCLES - 1 : 0);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;
`endif

    state_t state, state_nxt;

    // Latched command (data path, not reset: only meaningful after a load).
    logic              cmd_we_p0;
    logic [ADDR_W-1:0] cmd_addr_p0;
    logic [7:0]        cmd_wdata_p0;
    logic              cmd_load;
    logic [1:0]        cmd_bank;
    logic              cmd_hi;

    // Bank pin bundle.
    logic [NUM_BANKS-1:0] bank_sel;
    logic [NUM_BANKS-1:0] spram_cs;
    logic [NUM_BANKS-1:0] spram_wren;
    logic [NUM_BANKS-1:0] spram_sleep;
    logic [13:0]          spram_addr;
    logic [15:0]          spram_wdata;
    logic [3:0]           spram_maskwren;
    logic                 spram_standby;
    logic                 spram_poweroff;
    logic [15:0]          bank_dout [NUM_BANKS];
    logic [15:0]          sel_dout;

`ifdef SPRAM_POWERSAVE_EN
    logic [IDLE_W-1:0] idle_cnt;
    logic [WAKE_W-1:0] wake_cnt;
    logic              sleep_due;
`endif

    // Byte-lane steering helpers.
    function automatic logic [15:0] lane_wdata(input logic hi, input logic [7:0] b);
        return hi ? {b, 8'h00} : {8'h00, b};
    endfunction

    function automatic logic [3:0] lane_mask(input logic hi);
        return hi ? 4'b1100 : 4'b0011;
    endfunction

    function automatic logic [7:0] lane_rdata(input logic hi, input logic [15:0] w);
        return hi ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [15:0] nibble_bits(input logic [3:0] m);
        return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
    endfunction

    if (BANK_W > 0) begin : g_bank_idx
        assign cmd_bank = 2'(cmd_addr_p0[ADDR_W-1:15]);
    end else begin : g_one_bank
        assign cmd_bank = 2'd0;
    end

    assign cmd_hi = cmd_addr_p0[14];

`ifdef SPRAM_POWERSAVE_EN
    assign cmd_load  = req_i && (state == ST_IDLE || state == ST_SLEEP);
    assign sleep_due = (IDLE_SLEEP_CYCLES != 0) && (idle_cnt == IDLE_LAST);
`else
    assign cmd_load  = req_i && (state == ST_IDLE);
`endif

    // Command latch: captured only when a request is accepted.
    always_ff @(posedge clk) begin
        if (cmd_load) begin
            cmd_we_p0    <= we_i;
            cmd_addr_p0  <= addr_i;
            cmd_wdata_p0 <= wdata_i;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
`ifdef SPRAM_POWERSAVE_EN
                if (sleep_due) state_nxt = ST_SLEEP;
`endif
                if (req_i) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
`ifdef SPRAM_POWERSAVE_EN
            ST_SLEEP:  if (req_i) state_nxt = ST_WAKE;
            ST_WAKE:   if (wake_cnt == WAKE_LAST) state_nxt = ST_ACCESS;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

`ifdef SPRAM_POWERSAVE_EN
    // Idle and wake-up timers; both rest at zero outside their own state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            if (state == ST_IDLE && !req_i && !sleep_due) idle_cnt <= idle_cnt + 1'b1;
            else                                          idle_cnt <= '0;
            if (state == ST_WAKE) wake_cnt <= wake_cnt + 1'b1;
            else                  wake_cnt <= '0;
        end
    end

    assign spram_sleep = {NUM_BANKS{state == ST_SLEEP}};
    assign sleeping_o  = (state == ST_SLEEP) || (state == ST_WAKE);
    assign busy_o      = (state == ST_ACCESS) || (state == ST_RESP) || (state == ST_WAKE);
`else
    assign spram_sleep = '0;
    assign sleeping_o  = 1'b0;
    assign busy_o      = (state == ST_ACCESS) || (state == ST_RESP);
`endif

    // Bank decode; an index past NUM_BANKS selects nothing.
    always_comb begin
        bank_sel   = '0;
        spram_cs   = '0;
        spram_wren = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_sel[b]   = (int'(cmd_bank) == b);
            spram_cs[b]   = bank_sel[b] && (state == ST_ACCESS);
            spram_wren[b] = spram_cs[b] && cmd_we_p0;
        end
    end

    assign spram_addr     = cmd_addr_p0[13:0];
    assign spram_wdata    = lane_wdata(cmd_hi, cmd_wdata_p0);
    assign spram_maskwren = lane_mask(cmd_hi);
    assign spram_standby  = 1'b0;
    assign spram_poweroff = 1'b1;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [15:0] mem [0:16383];
        logic [15:0] dout_r;

        // Behavioural bank: masked nibble write or registered read when enabled and awake.
        always_ff @(posedge clk) begin
            if (spram_cs[b] && !spram_sleep[b] && !spram_standby && spram_poweroff) begin
                if (spram_wren[b]) begin
                    mem[spram_addr] <= (mem[spram_addr] & ~nibble_bits(spram_maskwren)) |
                                       (spram_wdata & nibble_bits(spram_maskwren));
                end else begin
                    dout_r <= mem[spram_addr];
                end
            end
        end

        assign bank_dout[b] = dout_r;
    end

    // Selected bank's word; zero when the bank index is out of range.
    always_comb begin
        sel_dout = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_sel[b]) sel_dout = bank_dout[b];
        end
    end

    // Response stage: ack pulse and read-lane capture on the RESP exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o   <= 1'b0;
            rdata_o <= 8'h00;
        end else begin
            ack_o <= (state == ST_RESP);
            if (state == ST_RESP && !cmd_we_p0) rdata_o <= lane_rdata(cmd_hi, sel_dout);
        end
    end

endmodule
